// File: rtl/mag_to_log_val.sv
// ---------------------------------------------------------------------------
// mag_to_log_val : 4-stage magnitude -> 8-bit log code with per-frame peak.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mag_to_log_val #(
  parameter int MAG_W     = 32,
  parameter int FRAC_BITS = 3,
  parameter int FLOOR     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] mag,
  input  logic             valid_in,
  input  logic             last_in,
  output logic [7:0]       log_val,
  output logic             valid_out,
  output logic             last_out,
  output logic [7:0]       frame_peak,
  output logic             frame_peak_valid
);

  localparam int IDX_W     = $clog2(MAG_W);
  localparam int RAW_W     = IDX_W + FRAC_BITS;
  localparam int WIN_W     = MAG_W + FRAC_BITS;
  localparam int WIN_IDX_W = $clog2(WIN_W);

  // stage 1
  logic [MAG_W-1:0] mag_s1_q, mag_s1_d;
  logic             v_s1_q, v_s1_d, l_s1_q, l_s1_d;
  // stage 2
  logic [MAG_W-1:0] mag_s2_q, mag_s2_d;
  logic [IDX_W-1:0] idx_s2_q, idx_s2_d;
  logic             zero_s2_q, zero_s2_d, v_s2_q, v_s2_d, l_s2_q, l_s2_d;
  // stage 3
  logic [RAW_W-1:0] raw_s3_q, raw_s3_d;
  logic             zero_s3_q, zero_s3_d, v_s3_q, v_s3_d, l_s3_q, l_s3_d;
  // stage 4 and peak tracking
  logic [7:0]       log_val_q, log_val_d, acc_q, acc_d;
  logic [7:0]       frame_peak_q, frame_peak_d;
  logic             valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic             fpv_q, fpv_d;

  logic [WIN_W-1:0] window;
  logic [FRAC_BITS-1:0] frac;
  int               diff;
  logic [7:0]       sat, log_new, peak_new;

  always_comb begin
    mag_s1_d  = mag;
    v_s1_d    = valid_in;
    l_s1_d    = last_in & valid_in;

    idx_s2_d  = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag_s1_q[i]) idx_s2_d = IDX_W'(i);
    end
    zero_s2_d = ~|mag_s1_q;
    mag_s2_d  = mag_s1_q;
    v_s2_d    = v_s1_q;
    l_s2_d    = l_s1_q;

    // Zero bits appended below the LSB give the right-padding for small idx.
    window    = {mag_s2_q, {FRAC_BITS{1'b0}}};
    frac      = window[WIN_IDX_W'(idx_s2_q) +: FRAC_BITS];
    raw_s3_d  = {idx_s2_q, frac};
    zero_s3_d = zero_s2_q;
    v_s3_d    = v_s2_q;
    l_s3_d    = l_s2_q;

    diff      = int'(raw_s3_q) - FLOOR;
    if (diff < 0)        sat = 8'd0;
    else if (diff > 255) sat = 8'd255;
    else                 sat = diff[7:0];
    log_new   = zero_s3_q ? 8'd0 : sat;
    peak_new  = (acc_q > log_new) ? acc_q : log_new;

    valid_out_d  = v_s3_q;
    log_val_d    = v_s3_q ? log_new : log_val_q;
    last_out_d   = v_s3_q ? l_s3_q  : last_out_q;
    acc_d        = acc_q;
    frame_peak_d = frame_peak_q;
    fpv_d        = 1'b0;
    if (v_s3_q) begin
      if (l_s3_q) begin
        frame_peak_d = peak_new;
        fpv_d        = 1'b1;
        acc_d        = 8'd0;
      end else begin
        acc_d        = peak_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_s1_q     <= '0;
      v_s1_q       <= 1'b0;
      l_s1_q       <= 1'b0;
      mag_s2_q     <= '0;
      idx_s2_q     <= '0;
      zero_s2_q    <= 1'b0;
      v_s2_q       <= 1'b0;
      l_s2_q       <= 1'b0;
      raw_s3_q     <= '0;
      zero_s3_q    <= 1'b0;
      v_s3_q       <= 1'b0;
      l_s3_q       <= 1'b0;
      log_val_q    <= '0;
      valid_out_q  <= 1'b0;
      last_out_q   <= 1'b0;
      acc_q        <= '0;
      frame_peak_q <= '0;
      fpv_q        <= 1'b0;
    end else begin
      mag_s1_q     <= mag_s1_d;
      v_s1_q       <= v_s1_d;
      l_s1_q       <= l_s1_d;
      mag_s2_q     <= mag_s2_d;
      idx_s2_q     <= idx_s2_d;
      zero_s2_q    <= zero_s2_d;
      v_s2_q       <= v_s2_d;
      l_s2_q       <= l_s2_d;
      raw_s3_q     <= raw_s3_d;
      zero_s3_q    <= zero_s3_d;
      v_s3_q       <= v_s3_d;
      l_s3_q       <= l_s3_d;
      log_val_q    <= log_val_d;
      valid_out_q  <= valid_out_d;
      last_out_q   <= last_out_d;
      acc_q        <= acc_d;
      frame_peak_q <= frame_peak_d;
      fpv_q        <= fpv_d;
    end
  end

  assign log_val          = log_val_q;
  assign valid_out        = valid_out_q;
  assign last_out         = last_out_q;
  assign frame_peak       = frame_peak_q;
  assign frame_peak_valid = fpv_q;

endmodule

`default_nettype wire

// File: tb/tb_mag_to_log_val.sv
// ---------------------------------------------------------------------------
// tb_mag_to_log_val : scoreboard bench driving FLOOR=0 and FLOOR=40 instances.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mag_to_log_val;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mag;
  logic        valid_in, last_in;
  logic [7:0]  log_val   [2];
  logic        valid_out [2];
  logic        last_out  [2];
  logic [7:0]  frame_peak[2];
  logic        fpv       [2];

  always #5 clk = ~clk;

  mag_to_log_val #(.MAG_W(32), .FRAC_BITS(3), .FLOOR(0)) dut0 (
    .clk(clk), .rst(rst), .mag(mag), .valid_in(valid_in), .last_in(last_in),
    .log_val(log_val[0]), .valid_out(valid_out[0]), .last_out(last_out[0]),
    .frame_peak(frame_peak[0]), .frame_peak_valid(fpv[0]));

  mag_to_log_val #(.MAG_W(32), .FRAC_BITS(3), .FLOOR(40)) dut1 (
    .clk(clk), .rst(rst), .mag(mag), .valid_in(valid_in), .last_in(last_in),
    .log_val(log_val[1]), .valid_out(valid_out[1]), .last_out(last_out[1]),
    .frame_peak(frame_peak[1]), .frame_peak_valid(fpv[1]));

  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] lv0;
    logic [7:0] lv1;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_log  [2];
  logic [7:0] exp_acc  [2];
  logic [7:0] exp_peak [2];
  logic       exp_last, exp_v, exp_pv;

  function automatic logic [7:0] ref_log(logic [31:0] m, int fl);
    int idx, frac, raw, v;
    if (m == 0) return 8'd0;
    idx = 0;
    for (int i = 0; i < 32; i++) if (m[i]) idx = i;
    if (idx >= 3) frac = int'((m >> (idx - 3)) & 32'd7);
    else          frac = int'((m << (3 - idx)) & 32'd7);
    raw = idx * 8 + frac;
    v   = raw - fl;
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    exp_t idle;
    idle.v = 1'b0; idle.l = 1'b0; idle.lv0 = 8'd0; idle.lv1 = 8'd0;
    sb = {};
    repeat (3) sb.push_back(idle);
  endtask

  task automatic step(logic r, logic v, logic l, logic [31:0] m);
    exp_t e, o;
    logic [7:0] mx;
    rst = r; valid_in = v; last_in = l; mag = m;
    e.v = v; e.l = l & v; e.lv0 = ref_log(m, 0); e.lv1 = ref_log(m, 40);
    @(posedge clk);
    #1;
    exp_pv = 1'b0;
    if (r) begin
      clear_sb();
      exp_v = 1'b0; exp_last = 1'b0;
      for (int f = 0; f < 2; f++) begin
        exp_log[f] = 8'd0; exp_acc[f] = 8'd0; exp_peak[f] = 8'd0;
      end
    end else begin
      sb.push_back(e);
      o = sb.pop_front();
      exp_v = o.v;
      if (o.v) begin
        exp_last   = o.l;
        exp_log[0] = o.lv0;
        exp_log[1] = o.lv1;
        for (int f = 0; f < 2; f++) begin
          mx = (exp_acc[f] > exp_log[f]) ? exp_acc[f] : exp_log[f];
          if (o.l) begin
            exp_peak[f] = mx;
            exp_acc[f]  = 8'd0;
          end else begin
            exp_acc[f]  = mx;
          end
        end
        exp_pv = o.l;
      end
    end
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("valid_out[%0d]", f),  32'(valid_out[f]),  32'(exp_v));
      chk($sformatf("log_val[%0d]", f),    32'(log_val[f]),    32'(exp_log[f]));
      chk($sformatf("last_out[%0d]", f),   32'(last_out[f]),   32'(exp_last));
      chk($sformatf("frame_peak[%0d]", f), 32'(frame_peak[f]), 32'(exp_peak[f]));
      chk($sformatf("peak_valid[%0d]", f), 32'(fpv[f]),        32'(exp_pv));
    end
  endtask

  initial begin
    logic [31:0] m;
    logic        v, l, r;
    rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; mag = '0;
    clear_sb();

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // back-to-back known codes
    step(0, 1, 0, 32'd1);
    step(0, 1, 0, 32'd5);
    step(0, 1, 0, 32'd12);
    step(0, 1, 0, 32'h8000_0000);
    step(0, 1, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'd0);
    repeat (5) step(0, 0, 0, 0);

    // gapped stream, last_in must be ignored while valid_in is low
    step(0, 1, 0, 32'd5);
    step(0, 0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0, 32'd7);
    step(0, 1, 0, 32'd12);
    step(0, 1, 0, 32'd1);
    repeat (5) step(0, 0, 0, 0);

    // reset kills an in-flight frame end
    step(0, 1, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'd12);
    step(0, 1, 1, 32'd5);
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // four-beat frame, then single-beat frame, then all-zero frame
    step(0, 1, 0, 32'd12);
    step(0, 1, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'd5);
    step(0, 1, 1, 32'd1);
    step(0, 1, 1, 32'd5);
    step(0, 0, 0, 0);
    step(0, 1, 0, 32'd0);
    step(0, 1, 1, 32'd0);
    repeat (5) step(0, 0, 0, 0);

    // random stream
    for (int k = 0; k < 10000; k++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 1999) == 0);
      m = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) m = 32'd0;
      step(r, v, l, m);
    end
    repeat (6) step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
